// File: rtl/pow2_antilog_pipe.sv
// Pipelined Mitchell antilog (2^x): signed Q log2 value in, unsigned Q magnitude out, 2 register stages.
// Define POW2_CORR_EN to apply the Mitchell mantissa correction in stage 1.
module pow2_antilog_pipe #(
    parameter int unsigned Bf              = 8,
    parameter int unsigned FIX_POINT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FIX_POINT_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FIX_POINT_WIDTH-1:0] out_data,
    output logic                       out_sat
);
    localparam int unsigned W    = FIX_POINT_WIDTH;
    localparam int unsigned KW   = W - Bf;
    localparam int unsigned MW   = Bf + 1;
    localparam int unsigned SW   = W + 1;
    localparam int unsigned KMAX = W - Bf - 1;
    localparam logic [MW-1:0] ONE = MW'(1) << Bf;

    typedef struct packed {
        logic [KW-1:0] k;
        logic [MW-1:0] m;
    } s1_t;

    typedef struct packed {
        logic          sat;
        logic [W-1:0]  data;
    } s2_t;

    logic          s1_valid;
    logic          s2_valid;
    s1_t           s1_q;
    s1_t           s1_d;
    s2_t           s2_q;
    s2_t           s2_d;
    logic          s2_load_c;
    logic          in_fire_c;
    logic [Bf-1:0] frac_c;
    logic [MW-1:0] mant_c;
    logic [KW:0]   k_mag_c;
    logic [SW-1:0] shifted_c;

    // Both stages advance whenever the output register is free or draining.
    assign s2_load_c = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load_c;
    assign in_fire_c = in_valid && in_ready;

    assign frac_c = in_data[Bf-1:0];

`ifdef POW2_CORR_EN
    localparam int unsigned PW = 2 * Bf + 1;
    logic [PW-1:0] prod_c;
    logic [MW-1:0] corr_c;

    // Mitchell error term f*(1-f)/4, at full product width before scaling down.
    assign prod_c = PW'(frac_c) * PW'(ONE - MW'(frac_c));
    assign corr_c = MW'(prod_c >> (Bf + 2));
    assign mant_c = ONE + MW'(frac_c) - corr_c;
`else
    assign mant_c = ONE + MW'(frac_c);
`endif

    assign s1_d = {in_data[W-1:Bf], mant_c};

    // Barrel shift of the mantissa by the signed exponent, with a guard bit above the result.
    always_comb begin
        k_mag_c   = '0;
        shifted_c = '0;
        s2_d      = '0;
        if (!s1_q.k[KW-1]) begin
            k_mag_c   = {1'b0, s1_q.k};
            shifted_c = SW'(s1_q.m) << k_mag_c;
            if ((k_mag_c > (KW+1)'(KMAX)) || shifted_c[W]) begin
                s2_d.sat  = 1'b1;
                s2_d.data = '1;
            end else begin
                s2_d.data = shifted_c[W-1:0];
            end
        end else begin
            k_mag_c   = (KW+1)'(0) - {s1_q.k[KW-1], s1_q.k};
            shifted_c = SW'(s1_q.m) >> k_mag_c;
            s2_d.data = shifted_c[W-1:0];
        end
    end

    // Stage 1: exponent and mantissa split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_fire_c) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage 2: shifted result, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_load_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_q.data;
    assign out_sat   = s2_q.sat;

endmodule
